drop_sequencer: RTL

//  Drives the t_act/t_lim/drop_en inputs of the seven-segment display/drop stage.

---
 rtl/drop_pkg.sv | 21 ++
 rtl/drop_sequencer_if.sv | 27 ++
 rtl/drop_sequencer_tick_gen.sv | 28 ++
 rtl/drop_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/drop_pkg.sv
// Shared types for the drop sequencer: 3-bit state encoding, default time width
// and the saturating counter step used for t_act.
package drop_pkg;

    localparam int TIME_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LIM = 3'd1,
        ST_COUNT    = 3'd2,
        ST_REQ      = 3'd3,
        ST_DROPPED  = 3'd4,
        ST_REJECTED = 3'd5
    } state_e;

    // Operates on a 32-bit container; callers pass their all-ones value as max.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/drop_sequencer_if.sv
// Operator/display-side signal bundle of the drop sequencer.
// slave = sequencer side, master = operator + display stage side.
interface drop_sequencer_if #(
    parameter int TIME_W = 16
);
    logic              start;
    logic [TIME_W-1:0] t_lim_in;
    logic              t_lim_valid;
    logic              drop_req;
    logic              drop_activated;
    logic [TIME_W-1:0] t_act;
    logic [TIME_W-1:0] t_lim;
    logic              drop_en;
    logic              busy;
    logic              drop_ok;
    logic              drop_fail;

    modport slave (
        input  start, t_lim_in, t_lim_valid, drop_req, drop_activated,
        output t_act, t_lim, drop_en, busy, drop_ok, drop_fail
    );

    modport master (
        output start, t_lim_in, t_lim_valid, drop_req, drop_activated,
        input  t_act, t_lim, drop_en, busy, drop_ok, drop_fail
    );
endinterface

// File: rtl/drop_sequencer_tick_gen.sv
// Prescaler: tick is high for one cycle every PRESCALE enabled cycles; counter
// is held at zero while en is low, so each enable window starts a full period.
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic          at_end;

    assign at_end = (cnt_q == CW'(PRESCALE - 1));
    assign tick_o = en_i && at_end;

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt_q <= '0;
        end else if (at_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/drop_sequencer.sv
// Drop sequencer: latches the time limit, counts elapsed ticks, issues drop_en and
// classifies the display stage's feedback as DROP/HOT. DROP_AUTOCLEAR_EN enables auto-return to IDLE.
module drop_sequencer
    import drop_pkg::*;
#(
    parameter int TIME_W     = TIME_W_DEF,
    parameter int PRESCALE   = 50000,
    parameter int HOLD_TICKS = 2000
) (
    input  logic              clk,
    input  logic              rst,
    drop_sequencer_if.slave   bus
);
    localparam logic [TIME_W-1:0] T_MAX = '1;

    state_e            state_q;
    logic [TIME_W-1:0] t_act_q;
    logic [TIME_W-1:0] t_lim_q;
    logic              drop_en_q;
    logic              busy_q;
    logic              drop_ok_q;
    logic              drop_fail_q;

    logic              tick_en;
    logic              tick;
    logic [TIME_W-1:0] t_act_d;

    assign t_act_d = TIME_W'(sat_inc(32'(t_act_q), 32'(T_MAX)));

`ifdef DROP_AUTOCLEAR_EN
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    logic [HW-1:0] hold_q;

    // The prescaler also paces the outcome hold time.
    always_comb begin
        tick_en = 1'b0;
        if (state_q == ST_COUNT || state_q == ST_DROPPED || state_q == ST_REJECTED) begin
            tick_en = 1'b1;
        end
    end
`else
    always_comb begin
        tick_en = 1'b0;
        if (state_q == ST_COUNT) begin
            tick_en = 1'b1;
        end
    end
`endif

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            t_act_q     <= '0;
            t_lim_q     <= '0;
            drop_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            drop_ok_q   <= 1'b0;
            drop_fail_q <= 1'b0;
`ifdef DROP_AUTOCLEAR_EN
            hold_q      <= '0;
`endif
        end else if (bus.start) begin
            // Restart from any state; wins over a coincident drop_req.
            state_q     <= ST_WAIT_LIM;
            t_act_q     <= '0;
            drop_en_q   <= 1'b0;
            busy_q      <= 1'b1;
            drop_ok_q   <= 1'b0;
            drop_fail_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LIM: begin
                    if (bus.t_lim_valid) begin
                        t_lim_q <= bus.t_lim_in;
                        t_act_q <= '0;
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (tick) begin
                        t_act_q <= t_act_d;
                    end
                    if (bus.drop_req) begin
                        drop_en_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    busy_q <= 1'b0;
`ifdef DROP_AUTOCLEAR_EN
                    hold_q <= '0;
`endif
                    if (bus.drop_activated) begin
                        drop_ok_q <= 1'b1;
                        state_q   <= ST_DROPPED;
                    end else begin
                        drop_fail_q <= 1'b1;
                        state_q     <= ST_REJECTED;
                    end
                end
                ST_DROPPED, ST_REJECTED: begin
`ifdef DROP_AUTOCLEAR_EN
                    if (tick) begin
                        if (hold_q == HW'(HOLD_TICKS - 1)) begin
                            hold_q      <= '0;
                            t_act_q     <= '0;
                            drop_en_q   <= 1'b0;
                            drop_ok_q   <= 1'b0;
                            drop_fail_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.t_act     = t_act_q;
    assign bus.t_lim     = t_lim_q;
    assign bus.drop_en   = drop_en_q;
    assign bus.busy      = busy_q;
    assign bus.drop_ok   = drop_ok_q;
    assign bus.drop_fail = drop_fail_q;
endmodule
